// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, PC constants and jump-address helper for the IF stage
package instruction_fetch_pkg;
  localparam int NB_REG_DEF = 32;
  localparam int NB_WIDHT_DEF = 9;
  localparam int NB_INST_DEF = 26;
  localparam logic [31:0] PC_RESET = 32'h0;
  localparam logic [31:0] PC_INC = 32'd4;
  function automatic logic [31:0] jump_addr(input logic [31:0] pc_plus4, input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction
endpackage

// File: rtl/instruction_fetch_instr_mem.sv
// instr_mem: word-addressed instruction memory, asynchronous read and synchronous write
module instr_mem #(
  parameter int NB_REG = 32,
  parameter int NB_ADDR = 7
) (
  input  logic              i_clk,
  input  logic              i_w_en,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_REG-1:0]  i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_REG-1:0]  o_data
);
  logic [NB_REG-1:0] mem [2**NB_ADDR];
  always_ff @(posedge i_clk)
    if (i_w_en) mem[i_waddr] <= i_wdata;
  assign o_data = mem[i_raddr];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, next-PC selection and instruction memory of the MIPS IF stage
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NB_REG = NB_REG_DEF,
  parameter int NB_WIDHT = NB_WIDHT_DEF,
  parameter int NB_INST = NB_INST_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_dunit_clk_en,
  input  logic                i_dunit_w_en,
  input  logic [NB_WIDHT-1:0] i_dunit_addr,
  input  logic                i_PCSrc,
  input  logic                i_Jump,
  input  logic                i_JSel,
  input  logic                i_PCWrite,
  input  logic [NB_REG-1:0]   i_inmed,
  input  logic [NB_INST-1:0]  i_inst_to_mxp,
  input  logic [NB_REG-1:0]   i_pc_jsel,
  input  logic [NB_REG-1:0]   i_dunit_data,
  output logic [NB_REG-1:0]   o_pcplus4,
  output logic [NB_REG-1:0]   o_instruction
);
  logic [NB_REG-1:0] pc, pc_plus4, j_addr, pc_next;
  logic unused_addr;
  assign unused_addr = ^i_dunit_addr[1:0];
  assign pc_plus4 = pc + NB_REG'(PC_INC);
  assign j_addr = {pc_plus4[NB_REG-1:NB_REG-4], i_inst_to_mxp, 2'b00};
  always_comb
    pc_next = i_JSel ? i_pc_jsel : i_Jump ? j_addr : i_PCSrc ? i_inmed : pc_plus4;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) pc <= NB_REG'(PC_RESET);
    else if (i_dunit_clk_en && i_PCWrite) pc <= pc_next;
  // a write on an edge where reset is held low is dropped
  instr_mem #(.NB_REG(NB_REG), .NB_ADDR(NB_WIDHT-2)) u_mem (
    .i_clk  (i_clk),
    .i_w_en (i_dunit_w_en && i_reset),
    .i_waddr(i_dunit_addr[NB_WIDHT-1:2]),
    .i_wdata(i_dunit_data),
    .i_raddr(pc[NB_WIDHT-1:2]),
    .o_data (o_instruction)
  );
  assign o_pcplus4 = pc_plus4;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table vectors, hand sequences and random run against a PC/memory model
module tb_instruction_fetch;
  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, w_en = 1'b0;
  logic [8:0] waddr = '0;
  logic pcsrc = 1'b0, jump = 1'b0, jsel = 1'b0, pcwrite = 1'b0;
  logic [31:0] inmed = '0, jv = '0, wdata = '0;
  logic [25:0] idx = '0;
  logic [31:0] pcplus4, instr;
  int vectors = 0, miscompares = 0;
  logic [31:0] m_mem [128];
  logic [31:0] m_pc;

  typedef struct {
    logic en, pw, src, jmp, jsl;
    logic [31:0] inmed;
    logic [25:0] idx;
    logic [31:0] jv, exp4;
  } vec_t;
  vec_t tbl[9];

  instruction_fetch dut (
    .i_clk(clk), .i_reset(rst_n), .i_dunit_clk_en(clk_en), .i_dunit_w_en(w_en),
    .i_dunit_addr(waddr), .i_PCSrc(pcsrc), .i_Jump(jump), .i_JSel(jsel), .i_PCWrite(pcwrite),
    .i_inmed(inmed), .i_inst_to_mxp(idx), .i_pc_jsel(jv), .i_dunit_data(wdata),
    .o_pcplus4(pcplus4), .o_instruction(instr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_ctl(input logic en, pw, src, jmp, jsl, input logic [31:0] im,
                         input logic [25:0] ix, input logic [31:0] j);
    clk_en = en; pcwrite = pw; pcsrc = src; jump = jmp; jsel = jsl; inmed = im; idx = ix; jv = j;
  endtask

  task automatic write_word(input logic [8:0] a, input logic [31:0] d);
    w_en = 1'b1; waddr = a; wdata = d;
    m_mem[a[8:2]] = d;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (jsel) return jv;
    if (jump) return {p4[31:28], idx, 2'b00};
    if (pcsrc) return inmed;
    return p4;
  endfunction

  initial begin
    logic [31:0] p;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h8};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 26'h0, 32'h0, 32'h24};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h28};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 26'h2AAAAAA, 32'h0, 32'h0AAAAAAC};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 26'h123, 32'h80, 32'h84};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 26'h123, 32'h200, 32'h84};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 26'h0, 32'h0, 32'h84};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h84};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 26'h5, 32'h300, 32'h84};

    #12;
    check("reset_pcplus4", pcplus4, 32'h4);
    rst_n = 1'b1;
    set_ctl(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 26'h0, 32'h0);
    for (int i = 0; i < 128; i++) begin
      write_word(9'(i * 4), $urandom);
      tick;
    end
    w_en = 1'b0;
    check("debug_halt_pc", pcplus4, 32'h4);
    check("mem0_read", instr, m_mem[0]);

    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      set_ctl(tbl[i].en, tbl[i].pw, tbl[i].src, tbl[i].jmp, tbl[i].jsl, tbl[i].inmed, tbl[i].idx, tbl[i].jv);
      tick;
      p = tbl[i].exp4 - 32'd4;
      check($sformatf("tbl%0d_pcplus4", i), pcplus4, tbl[i].exp4);
      check($sformatf("tbl%0d_instr", i), instr, m_mem[p[8:2]]);
    end

    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h80);
    tick;
    check("pc_at_80", pcplus4, 32'h84);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0);
    p = m_mem[32];
    write_word(9'h081, 32'hCAFEF00D);
    #2;
    check("old_word_before_edge", instr, p);
    tick;
    check("new_word_after_edge", instr, 32'hCAFEF00D);
    write_word(9'h084, 32'hDEADBEEF);
    tick;
    check("write_other_word", instr, 32'hCAFEF00D);
    write_word(9'h100, 32'h12345678);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 26'h0, 32'h84);
    tick;
    w_en = 1'b0;
    check("pc_84_instr", instr, 32'hDEADBEEF);
    jv = 32'h100;
    tick;
    check("simul_write_read", instr, 32'h12345678);
    jv = 32'h284;
    tick;
    check("alias_284_instr", instr, 32'hDEADBEEF);
    check("alias_284_pcplus4", pcplus4, 32'h288);
    jv = 32'h84;
    tick;
    check("pc_84_again", pcplus4, 32'h88);

    rst_n = 1'b0;
    #1;
    check("async_reset_pc", pcplus4, 32'h4);
    w_en = 1'b1; waddr = 9'h000; wdata = 32'h55555555;
    tick;
    w_en = 1'b0;
    check("write_blocked_in_reset", instr, m_mem[0]);
    rst_n = 1'b1;
    tick;
    check("retained_after_reset", instr, 32'hDEADBEEF);

    rst_n = 1'b0;
    m_pc = 32'h0;
    tick;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      set_ctl($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), $urandom, 26'($urandom), $urandom);
      w_en = 1'($urandom); waddr = 9'($urandom); wdata = $urandom;
      if (!rst_n) m_pc = 32'h0;
      else begin
        if (w_en) m_mem[waddr[8:2]] = wdata;
        if (clk_en && pcwrite) m_pc = model_next(m_pc);
      end
      tick;
      check($sformatf("rnd%0d_pcplus4", n), pcplus4, m_pc + 32'd4);
      check($sformatf("rnd%0d_instr", n), instr, m_mem[m_pc[8:2]]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
